// File: rtl/mm_pkg.sv
// Shared constants and replay-FSM encoding for the 3x3 matrix-multiply slice.
package mm_pkg;
  localparam int DATA_W = 8;
  localparam int N      = 3;
  localparam int FRAME  = 2 * N * N;
  localparam int CNT_W  = $clog2(FRAME);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_FEED  = 2'd2,
    ST_WAIT  = 2'd3
  } feed_state_e;
endpackage

// File: rtl/matrix_feeder_if.sv
// Host operand stream plus core-side start/data/done signals of the matrix feeder.
interface matrix_feeder_if;
  import mm_pkg::*;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mm_start;
  logic [DATA_W-1:0] mm_data;
  logic              mm_done;
  logic              busy;
  logic [7:0]        frame_cnt;

  modport master (
    output in_data, in_valid, mm_done,
    input  in_ready, mm_start, mm_data, busy, frame_cnt
  );

  modport slave (
    input  in_data, in_valid, mm_done,
    output in_ready, mm_start, mm_data, busy, frame_cnt
  );
endinterface

// File: rtl/pingpong_bank.sv
// Two-bank frame store: one synchronous write port, one asynchronous read port.
module pingpong_bank
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              wbank,
  input  logic [CNT_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rbank,
  input  logic [CNT_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_r [2][FRAME];

  // Contents are qualified by the owner's full flags, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wbank][waddr] <= wdata;
    end
  end

  assign rdata = mem_r[rbank][raddr];
endmodule

// File: rtl/matrix_feeder.sv
// Buffers host operand frames in a ping-pong store and replays each one to the
// matrix core as a start pulse followed by one byte per cycle.
module matrix_feeder
  import mm_pkg::*;
(
  input logic            clk,
  input logic            rst,
  matrix_feeder_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  feed_state_e       state_r;
  feed_state_e       next_state_s;
  logic [1:0]        full_r;
  logic [1:0]        full_next_s;
  logic              wbank_r;
  logic              rbank_r;
  logic [CNT_W-1:0]  wcnt_r;
  logic [CNT_W-1:0]  rcnt_r;
  logic [CNT_W-1:0]  raddr_s;
  logic [DATA_W-1:0] rdata_s;
  logic [DATA_W-1:0] mm_data_r;
  logic              mm_start_r;
  logic              busy_r;
  logic [7:0]        frame_cnt_r;
  logic              wr_en_s;
  logic              wr_last_s;
  logic              free_s;

  assign wr_en_s   = bus.in_valid & ~full_r[wbank_r];
  assign wr_last_s = wr_en_s & (wcnt_r == LAST);
  assign free_s    = (state_r == ST_WAIT) & bus.mm_done;

  // Set and clear can hit different banks in one cycle; both must land.
  assign full_next_s = (full_r | (wr_last_s ? (2'b01 << wbank_r) : 2'b00))
                     & ~(free_s ? (2'b01 << rbank_r) : 2'b00);

  pingpong_bank u_bank (
    .clk   (clk),
    .we    (wr_en_s),
    .wbank (wbank_r),
    .waddr (wcnt_r),
    .wdata (bus.in_data),
    .rbank (rbank_r),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Read address of the byte to present on the next cycle.
  always_comb begin
    raddr_s = '0;
    if ((state_r == ST_FEED) && (rcnt_r != LAST)) begin
      raddr_s = rcnt_r + CNT_W'(1);
    end else begin
      raddr_s = '0;
    end
  end

  // Replay FSM next-state decode; mm_done only matters in WAIT.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (full_r[rbank_r]) next_state_s = ST_START;
        else                 next_state_s = ST_IDLE;
      end
      ST_START: next_state_s = ST_FEED;
      ST_FEED: begin
        if (rcnt_r == LAST) next_state_s = ST_WAIT;
        else                next_state_s = ST_FEED;
      end
      ST_WAIT: begin
        if (bus.mm_done) next_state_s = ST_IDLE;
        else             next_state_s = ST_WAIT;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, counters, flags and the registered core-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      full_r      <= 2'b00;
      wbank_r     <= 1'b0;
      rbank_r     <= 1'b0;
      wcnt_r      <= '0;
      rcnt_r      <= '0;
      mm_start_r  <= 1'b0;
      mm_data_r   <= '0;
      busy_r      <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else begin
      state_r <= next_state_s;
      full_r  <= full_next_s;
      rcnt_r  <= raddr_s;
      if (wr_en_s) begin
        wcnt_r <= wr_last_s ? '0 : wcnt_r + CNT_W'(1);
      end
      if (wr_last_s) begin
        wbank_r <= ~wbank_r;
      end
      if (free_s) begin
        rbank_r     <= ~rbank_r;
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end
      // Outputs are decoded from next state so they line up with state_r.
      mm_start_r <= (next_state_s == ST_START);
      mm_data_r  <= (next_state_s == ST_FEED) ? rdata_s : '0;
      busy_r     <= (next_state_s != ST_IDLE);
    end
  end

  assign bus.in_ready  = ~full_r[wbank_r];
  assign bus.mm_start  = mm_start_r;
  assign bus.mm_data   = mm_data_r;
  assign bus.busy      = busy_r;
  assign bus.frame_cnt = frame_cnt_r;
endmodule

// File: tb/tb_matrix_feeder.sv
// Directed + randomised bench for matrix_feeder; accepted bytes go to a queue and
// are popped as the feeder replays them.
module tb_matrix_feeder;
  import mm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_feeder_if bus();
  matrix_feeder dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [7:0] exp_fc = 8'd0;
  int feed_left = 0;
  int wait_ctr = 0;
  int max_delay = 0;
  logic auto_mode = 1'b0;
  logic done_man = 1'b0;
  logic done_auto = 1'b0;

  assign bus.mm_done = done_man | done_auto;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Core-side monitor: pops expected bytes, checks idle data, optionally answers done.
  always @(negedge clk) begin
    int feed_before;
    if (rst) begin
      feed_left = 0;
      wait_ctr  = 0;
      done_auto = 1'b0;
    end else begin
      feed_before = feed_left;
      done_auto = 1'b0;
      if (wait_ctr > 0) begin
        wait_ctr--;
        if (wait_ctr == 0 && auto_mode) begin
          done_auto = 1'b1;
          exp_fc++;
        end
      end
      if (feed_left > 0) begin
        if (exp_q.size() > 0) chk("mm_data", 32'(bus.mm_data), 32'(exp_q.pop_front()));
        else chk("queue_depth", 32'(exp_q.size()), 32'd1);
        chk("busy_feed", 32'(bus.busy), 32'd1);
        feed_left--;
        if (feed_left == 0) wait_ctr = 1 + (auto_mode ? int'($urandom_range(0, max_delay)) : 0);
      end else begin
        chk("mm_data_idle", 32'(bus.mm_data), 32'd0);
      end
      if (bus.mm_start) begin
        chk("start_during_feed", 32'(feed_before), 32'd0);
        chk("start_with_frame", 32'(exp_q.size() >= FRAME), 32'd1);
        chk("frame_cnt_at_start", 32'(bus.frame_cnt), 32'(exp_fc));
        feed_left = FRAME;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] b);
    int n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 300) begin
      tick();
      n++;
    end
    if (bus.in_ready) begin
      exp_q.push_back(b);
      tick();
    end else begin
      chk("send_timeout", 32'(n), 32'd0);
    end
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bus.mm_start && n < 300) begin
      tick();
      n++;
    end
    chk("start_seen", 32'(bus.mm_start), 32'd1);
  endtask

  task automatic wait_wait();
    int n = 0;
    while (!(bus.busy && !bus.mm_start && feed_left == 0) && n < 300) begin
      tick();
      n++;
    end
    chk("wait_reached", 32'(n < 300), 32'd1);
    tick();
  endtask

  task automatic pulse_done();
    done_man = 1'b1;
    tick();
    done_man = 1'b0;
    exp_fc++;
    chk("frame_cnt_after_done", 32'(bus.frame_cnt), 32'(exp_fc));
    chk("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (!(exp_q.size() == 0 && feed_left == 0 && !bus.busy) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mm_start", 32'(bus.mm_start), 32'd0);
    chk("rst_mm_data", 32'(bus.mm_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // One frame 1..18, latency and in_ready during replay.
    for (int i = 1; i <= FRAME; i++) send(8'(i));
    bus.in_valid = 1'b0;
    chk("lat_no_start_yet", 32'(bus.mm_start), 32'd0);
    chk("lat_idle", 32'(bus.busy), 32'd0);
    tick();
    chk("lat_start", 32'(bus.mm_start), 32'd1);
    chk("start_busy", 32'(bus.busy), 32'd1);
    chk("start_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("first_byte", 32'(bus.mm_data), 32'd1);
    chk("no_second_start", 32'(bus.mm_start), 32'd0);
    wait_wait();
    chk("wait_in_ready", 32'(bus.in_ready), 32'd1);
    chk("wait_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    pulse_done();

    // Both banks filled with done withheld, then release.
    for (int i = 1; i <= 2 * FRAME; i++) send(8'(i));
    bus.in_valid = 1'b0;
    chk("both_full_ready", 32'(bus.in_ready), 32'd0);
    wait_wait();
    chk("both_full_hold", 32'(bus.in_ready), 32'd0);
    pulse_done();
    chk("freed_ready", 32'(bus.in_ready), 32'd1);
    wait_wait();
    pulse_done();

    // mm_done during FEED is ignored.
    for (int i = 1; i <= FRAME; i++) send(8'(100 + i));
    bus.in_valid = 1'b0;
    wait_start();
    repeat (3) tick();
    done_man = 1'b1;
    repeat (4) tick();
    done_man = 1'b0;
    chk("early_done_cnt", 32'(bus.frame_cnt), 32'(exp_fc));
    chk("early_done_busy", 32'(bus.busy), 32'd1);
    wait_wait();
    chk("early_done_wait_cnt", 32'(bus.frame_cnt), 32'(exp_fc));
    pulse_done();

    // Random gaps with delayed done so the host sees in_ready stalls.
    auto_mode = 1'b1;
    max_delay = 25;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      send(8'($urandom));
    end
    bus.in_valid = 1'b0;
    drain();
    auto_mode = 1'b0;
    chk("rand_frame_cnt", 32'(bus.frame_cnt), 32'(exp_fc));

    // Reset while byte 7 is on mm_data.
    for (int i = 1; i <= FRAME; i++) send(8'(i));
    bus.in_valid = 1'b0;
    wait_start();
    repeat (7) tick();
    rst = 1'b1;
    #1;
    chk("midrst_mm_start", 32'(bus.mm_start), 32'd0);
    chk("midrst_mm_data", 32'(bus.mm_data), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    exp_fc = 8'd0;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 1; i <= FRAME; i++) send(8'(50 + i));
    bus.in_valid = 1'b0;
    wait_wait();
    pulse_done();

    // 257 frames with immediate done: counter wraps to 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_fc = 8'd0;
    exp_q.delete();
    tick();
    auto_mode = 1'b1;
    max_delay = 0;
    for (int f = 0; f < 257; f++) begin
      for (int i = 0; i < FRAME; i++) send(8'(f + 7 * i));
    end
    bus.in_valid = 1'b0;
    drain();
    chk("wrap_frame_cnt", 32'(bus.frame_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
